// File: rtl/cheriot_dv_mem_cmd_mon_if.sv
// ---------------------------------------------------------------------------
// cheriot_dv_mem_cmd_mon_if : observed memory ports plus the command record stream
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cheriot_dv_mem_cmd_mon_if #(
   parameter int NCh = 2
);
   logic [NCh-1:0]    req_i;
   logic [NCh-1:0]    gnt_i;
   logic [NCh-1:0]    we_i;
   logic [NCh-1:0]    is_cap_i;
   logic [NCh*4-1:0]  be_i;
   logic [NCh*32-1:0] addr_i;
   logic [NCh*33-1:0] wdata_i;
   logic [NCh-1:0]    rvalid_i;
   logic [NCh*33-1:0] rdata_i;
   logic [NCh-1:0]    err_i;
   logic              cmd_valid_o;
   logic              cmd_ready_i;
   logic [112:0]      cmd_o;

   modport master (
      output req_i, gnt_i, we_i, is_cap_i, be_i, addr_i, wdata_i,
      output rvalid_i, rdata_i, err_i, cmd_ready_i,
      input  cmd_valid_o, cmd_o
   );

   modport slave (
      input  req_i, gnt_i, we_i, is_cap_i, be_i, addr_i, wdata_i,
      input  rvalid_i, rdata_i, err_i, cmd_ready_i,
      output cmd_valid_o, cmd_o
   );
endinterface

`default_nettype wire

// File: rtl/cheriot_dv_mem_cmd_mon.sv
// ---------------------------------------------------------------------------
// cheriot_dv_mem_cmd_mon : pairs granted requests with in-order responses per
// channel and streams completed command records through a round-robin skid slot
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cheriot_dv_mem_cmd_mon #(
   parameter int NCh            = 2,
   parameter int MaxOutstanding = 4,
   parameter int CplDepth       = 4,
   parameter int SeqW           = 5
) (
   input  wire logic                   clk_i,
   input  wire logic                   rst_ni,
   cheriot_dv_mem_cmd_mon_if.slave     mem,
   output logic [NCh-1:0]              pend_ovf_o,
   output logic [NCh-1:0]              orphan_o,
   output logic [NCh-1:0]              cpl_drop_o,
   output logic [15:0]                 drop_cnt_o
);
   localparam int CMD_W  = 113;
   localparam int PEND_W = $clog2(MaxOutstanding);
   localparam int CPL_W  = $clog2(CplDepth);
   localparam int RR_W   = (NCh > 1) ? $clog2(NCh) : 1;

   typedef struct packed {
      logic            is_cap;
      logic            we;
      logic [3:0]      be;
      logic [29:0]     addr;
      logic [32:0]     wdata;
      logic [SeqW-1:0] seq;
   } pend_t;

   logic [NCh-1:0]   cpl_nonempty;
   logic [NCh-1:0]   cpl_pop;
   logic [NCh-1:0]   drop_now;
   logic [CMD_W-1:0] cpl_head [NCh];

   for (genvar c = 0; c < NCh; c++) begin : g_ch
      pend_t             pq [MaxOutstanding];
      logic [PEND_W:0]   pq_wp, pq_rp;
      logic [SeqW-1:0]   seq;
      logic [CMD_W-1:0]  cq [CplDepth];
      logic [CPL_W:0]    cq_wp, cq_rp;
      logic              ovf_q, orphan_q, drop_q;
      logic              accept, pq_empty, pq_full, pq_pop, pq_push;
      logic              cq_full, cq_push;
      pend_t             head, entry;
      logic [7:0]        flag;
      logic [CMD_W-1:0]  rec;
      logic [1:0]        addr_lsbs;
      logic              unused_addr_lsbs;

      assign accept   = mem.req_i[c] & mem.gnt_i[c];
      assign pq_empty = (pq_wp == pq_rp);
      assign pq_full  = (pq_wp[PEND_W] != pq_rp[PEND_W]) &&
                        (pq_wp[PEND_W-1:0] == pq_rp[PEND_W-1:0]);
      // A response never matches the request granted in the same cycle
      assign pq_pop   = mem.rvalid_i[c] & ~pq_empty;
      assign pq_push  = accept & (~pq_full | pq_pop);

      assign entry = {mem.is_cap_i[c], mem.we_i[c], mem.be_i[c*4 +: 4],
                      mem.addr_i[c*32+2 +: 30],
                      mem.we_i[c] ? mem.wdata_i[c*33 +: 33] : 33'd0, seq};
      assign addr_lsbs        = mem.addr_i[c*32 +: 2];
      assign unused_addr_lsbs = ^addr_lsbs;

      assign head = pq[pq_rp[PEND_W-1:0]];
      assign flag = (8'(c) << SeqW) | 8'(head.seq);
      assign rec  = {flag, head.is_cap, head.we, head.be, 2'b00, head.addr, head.wdata,
                     head.we ? 33'd0 : mem.rdata_i[c*33 +: 33], mem.err_i[c]};

      assign cq_full = (cq_wp[CPL_W] != cq_rp[CPL_W]) &&
                       (cq_wp[CPL_W-1:0] == cq_rp[CPL_W-1:0]);
      assign cq_push = pq_pop & (~cq_full | cpl_pop[c]);

      assign drop_now[c]     = pq_pop & cq_full & ~cpl_pop[c];
      assign cpl_nonempty[c] = (cq_wp != cq_rp);
      assign cpl_head[c]     = cq[cq_rp[CPL_W-1:0]];
      assign pend_ovf_o[c]   = ovf_q;
      assign orphan_o[c]     = orphan_q;
      assign cpl_drop_o[c]   = drop_q;

      always_ff @(posedge clk_i) begin
         if (pq_push) pq[pq_wp[PEND_W-1:0]] <= entry;
         if (cq_push) cq[cq_wp[CPL_W-1:0]] <= rec;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            pq_wp    <= '0;
            pq_rp    <= '0;
            seq      <= '0;
            cq_wp    <= '0;
            cq_rp    <= '0;
            ovf_q    <= 1'b0;
            orphan_q <= 1'b0;
            drop_q   <= 1'b0;
         end else begin
            if (pq_push) begin
               pq_wp <= pq_wp + 1'b1;
               seq   <= seq + 1'b1;
            end
            if (pq_pop)     pq_rp <= pq_rp + 1'b1;
            if (cq_push)    cq_wp <= cq_wp + 1'b1;
            if (cpl_pop[c]) cq_rp <= cq_rp + 1'b1;
            ovf_q    <= ovf_q | (accept & pq_full & ~pq_pop);
            orphan_q <= orphan_q | (mem.rvalid_i[c] & pq_empty);
            drop_q   <= drop_q | drop_now[c];
         end
      end
   end

   logic              out_valid;
   logic [CMD_W-1:0]  out_data;
   logic [RR_W-1:0]   rr;
   logic [RR_W-1:0]   winner;
   logic [RR_W:0]     cand;
   logic              found;
   logic              load;
   logic [15:0]       drop_cnt;
   logic [3:0]        drop_sum;
   logic [16:0]       drop_next;

   // Skid slot refills whenever it is empty or being handed off this cycle
   always_comb begin
      load    = ~out_valid | mem.cmd_ready_i;
      found   = 1'b0;
      winner  = '0;
      cand    = '0;
      cpl_pop = '0;
      for (int i = 0; i < NCh; i++) begin
         cand = {1'b0, rr} + (RR_W+1)'(i);
         if (cand >= (RR_W+1)'(NCh)) cand = cand - (RR_W+1)'(NCh);
         if (!found && cpl_nonempty[cand[RR_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[RR_W-1:0];
         end
      end
      if (load && found) cpl_pop[winner] = 1'b1;
   end

   always_comb begin
      drop_sum = '0;
      for (int i = 0; i < NCh; i++) drop_sum = drop_sum + {3'b000, drop_now[i]};
      drop_next = {1'b0, drop_cnt} + {13'd0, drop_sum};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         rr        <= '0;
         drop_cnt  <= '0;
      end else begin
         if (load) begin
            out_valid <= found;
            if (found) begin
               out_data <= cpl_head[winner];
               rr       <= (winner == RR_W'(NCh-1)) ? '0 : winner + 1'b1;
            end
         end
         drop_cnt <= drop_next[16] ? 16'hFFFF : drop_next[15:0];
      end
   end

   assign mem.cmd_valid_o = out_valid;
   assign mem.cmd_o       = out_data;
   assign drop_cnt_o      = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cheriot_dv_mem_cmd_mon.sv
// ---------------------------------------------------------------------------
// tb_cheriot_dv_mem_cmd_mon : directed, table-driven bench for the command monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cheriot_dv_mem_cmd_mon;
   localparam int NCh = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  pend_ovf, orphan, cpl_drop;
   logic [15:0] drop_cnt;
   int          checks = 0;
   int          failures = 0;
   logic [112:0] got [$];

   cheriot_dv_mem_cmd_mon_if #(.NCh(NCh)) bus ();

   cheriot_dv_mem_cmd_mon #(
      .NCh(NCh), .MaxOutstanding(4), .CplDepth(4), .SeqW(5)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .mem(bus),
      .pend_ovf_o(pend_ovf), .orphan_o(orphan),
      .cpl_drop_o(cpl_drop), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.cmd_valid_o && bus.cmd_ready_i) got.push_back(bus.cmd_o);

   typedef struct {
      int          ch;
      logic        we;
      logic        is_cap;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [32:0] wdata;
      logic [32:0] rdata;
      logic        err;
      logic [7:0]  e_flag;
      logic [29:0] e_a30;
      logic [32:0] e_wd;
      logic [32:0] e_rd;
   } vec_t;

   vec_t vecs [5];
   vec_t v;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [112:0] mk_rec(input logic [7:0] flag, input logic is_cap,
                                           input logic we, input logic [3:0] be,
                                           input logic [29:0] a30, input logic [32:0] wd,
                                           input logic [32:0] rd, input logic err);
      return {flag, is_cap, we, be, 2'b00, a30, wd, rd, err};
   endfunction

   function automatic logic [112:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 'x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.req_i = '0; bus.gnt_i = '0; bus.we_i = '0; bus.is_cap_i = '0;
      bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
      bus.rvalid_i = '0; bus.rdata_i = '0; bus.err_i = '0;
   endtask

   task automatic set_req(input int ch, input logic we, input logic cap, input logic [3:0] be,
                          input logic [31:0] addr, input logic [32:0] wd);
      bus.req_i[ch] = 1'b1; bus.gnt_i[ch] = 1'b1;
      bus.we_i[ch] = we; bus.is_cap_i[ch] = cap;
      bus.be_i[ch*4 +: 4] = be;
      bus.addr_i[ch*32 +: 32] = addr;
      bus.wdata_i[ch*33 +: 33] = wd;
   endtask

   task automatic set_rsp(input int ch, input logic [32:0] rd, input logic err);
      bus.rvalid_i[ch] = 1'b1;
      bus.rdata_i[ch*33 +: 33] = rd;
      bus.err_i[ch] = err;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      got.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 1'b0, 4'hF, 32'h8000_0010, 33'h0_1234_5678, 33'h1_DEAD_BEEF, 1'b0,
                  8'h00, 30'h2000_0004, 33'h0, 33'h1_DEAD_BEEF};
      vecs[1] = '{1, 1'b1, 1'b0, 4'h3, 32'h0000_1004, 33'h1_0000_00AA, 33'h0_FFFF_FFFF, 1'b1,
                  8'h20, 30'h0000_0401, 33'h1_0000_00AA, 33'h0};
      vecs[2] = '{0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 33'h1_CAFE_F00D, 33'h1_1111_1111, 1'b0,
                  8'h01, 30'h3FFF_FFFF, 33'h1_CAFE_F00D, 33'h0};
      vecs[3] = '{1, 1'b0, 1'b0, 4'h1, 32'h0000_0003, 33'h1_FFFF_FFFF, 33'h0_0000_0055, 1'b0,
                  8'h21, 30'h0, 33'h0, 33'h0_0000_0055};
      vecs[4] = '{0, 1'b0, 1'b0, 4'hC, 32'h0000_0100, 33'h0, 33'h1_0000_0000, 1'b1,
                  8'h02, 30'h0000_0040, 33'h0, 33'h1_0000_0000};

      clear_in();
      bus.cmd_ready_i = 1'b1;
      step();
      step();
      check("rst_valid", bus.cmd_valid_o, 0);
      check("rst_cmd", bus.cmd_o, 0);
      check("rst_flags", {pend_ovf, orphan, cpl_drop}, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;

      // Single transactions from the table, including the 2-cycle latency
      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         got.delete();
         set_req(v.ch, v.we, v.is_cap, v.be, v.addr, v.wdata);
         step();
         clear_in();
         set_rsp(v.ch, v.rdata, v.err);
         step();
         clear_in();
         check($sformatf("vec%0d_lat1", i), bus.cmd_valid_o, 0);
         step();
         check($sformatf("vec%0d_valid", i), bus.cmd_valid_o, 1);
         check($sformatf("vec%0d_rec", i), bus.cmd_o,
               mk_rec(v.e_flag, v.is_cap, v.we, v.be, v.e_a30, v.e_wd, v.e_rd, v.err));
         step();
         check($sformatf("vec%0d_count", i), got.size(), 1);
      end

      // Pipelined writes on ch1 and pending-queue overflow
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b1, 1'b0, 4'hF, 32'h100 + 32'(4*i), 33'(i+1));
         step();
      end
      clear_in();
      check("pipe_no_ovf", pend_ovf, 0);
      set_req(1, 1'b1, 1'b0, 4'hF, 32'h110, 33'd5);
      step();
      clear_in();
      check("pipe_ovf", pend_ovf, 2'b10);
      for (int i = 0; i < 4; i++) begin
         set_rsp(1, 33'h1_0000_0000 + 33'(i), 1'b0);
         step();
      end
      clear_in();
      repeat (4) step();
      check("pipe_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("pipe_rec%0d", i), got_at(i),
               mk_rec(8'(8'h20 + i), 1'b0, 1'b1, 4'hF, 30'(32'h40 + i), 33'(i+1), 33'h0, 1'b0));

      // Simultaneous completions on both channels alternate
      do_reset();
      for (int i = 0; i < 2; i++) begin
         set_req(0, 1'b0, 1'b0, 4'hF, 32'h300 + 32'(4*i), 33'h0);
         set_req(1, 1'b0, 1'b0, 4'hF, 32'h400 + 32'(4*i), 33'h0);
         step();
      end
      clear_in();
      for (int i = 0; i < 2; i++) begin
         set_rsp(0, 33'h0_AAAA_0000 + 33'(i), 1'b0);
         set_rsp(1, 33'h0_BBBB_0000 + 33'(i), 1'b0);
         step();
      end
      clear_in();
      repeat (5) step();
      check("rr_count", got.size(), 4);
      check("rr_rec0", got_at(0), mk_rec(8'h00, 1'b0, 1'b0, 4'hF, 30'h0C0, 33'h0, 33'h0_AAAA_0000, 1'b0));
      check("rr_rec1", got_at(1), mk_rec(8'h20, 1'b0, 1'b0, 4'hF, 30'h100, 33'h0, 33'h0_BBBB_0000, 1'b0));
      check("rr_rec2", got_at(2), mk_rec(8'h01, 1'b0, 1'b0, 4'hF, 30'h0C1, 33'h0, 33'h0_AAAA_0001, 1'b0));
      check("rr_rec3", got_at(3), mk_rec(8'h21, 1'b0, 1'b0, 4'hF, 30'h101, 33'h0, 33'h0_BBBB_0001, 1'b0));
      check("rr_no_drop", {cpl_drop, drop_cnt}, 0);

      // Backpressure: 6 reads on ch0 with the stream stalled for 12 cycles
      do_reset();
      bus.cmd_ready_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         clear_in();
         if (i < 6) set_req(0, 1'b0, 1'b0, 4'hF, 32'h200 + 32'(4*i), 33'h0);
         if (i > 0) set_rsp(0, 33'h1_0000_0010 + 33'(i-1), 1'b0);
         step();
         if (i == 3)
            check("bp_hold_early", bus.cmd_o,
                  mk_rec(8'h00, 1'b0, 1'b0, 4'hF, 30'h80, 33'h0, 33'h1_0000_0010, 1'b0));
      end
      clear_in();
      repeat (5) step();
      check("bp_valid", bus.cmd_valid_o, 1);
      check("bp_hold_late", bus.cmd_o,
            mk_rec(8'h00, 1'b0, 1'b0, 4'hF, 30'h80, 33'h0, 33'h1_0000_0010, 1'b0));
      check("bp_cpl_drop", cpl_drop, 2'b01);
      check("bp_drop_cnt", drop_cnt, 1);
      bus.cmd_ready_i = 1'b1;
      repeat (8) step();
      check("bp_count", got.size(), 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("bp_rec%0d", k), got_at(k),
               mk_rec(8'(k), 1'b0, 1'b0, 4'hF, 30'(32'h80 + k), 33'h0, 33'h1_0000_0010 + 33'(k), 1'b0));

      // Orphan responses and same-cycle grant/response corners
      do_reset();
      set_rsp(1, 33'h0_0000_1234, 1'b0);
      step();
      clear_in();
      check("orph_flag", orphan, 2'b10);
      repeat (3) step();
      check("orph_no_rec", got.size(), 0);
      check("orph_idle", bus.cmd_valid_o, 0);
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h40, 33'h0);
      set_rsp(0, 33'h77, 1'b0);
      step();
      clear_in();
      check("orph_same_cycle", orphan, 2'b11);
      set_rsp(0, 33'h88, 1'b0);
      step();
      clear_in();
      repeat (3) step();
      check("orph_push_count", got.size(), 1);
      check("orph_push_rec", got_at(0), mk_rec(8'h00, 1'b0, 1'b0, 4'hF, 30'h10, 33'h0, 33'h88, 1'b0));
      got.delete();
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b0, 1'b0, 4'hF, 32'h500 + 32'(4*i), 33'h0);
         step();
      end
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h510, 33'h0);
      set_rsp(0, 33'h99, 1'b0);
      step();
      clear_in();
      check("full_swap_no_ovf", pend_ovf, 0);
      for (int i = 0; i < 4; i++) begin
         set_rsp(0, 33'h100 + 33'(i), 1'b0);
         step();
      end
      clear_in();
      repeat (4) step();
      check("full_swap_count", got.size(), 5);
      check("full_swap_first", got_at(0), mk_rec(8'h01, 1'b0, 1'b0, 4'hF, 30'h140, 33'h0, 33'h99, 1'b0));
      check("full_swap_last", got_at(4), mk_rec(8'h05, 1'b0, 1'b0, 4'hF, 30'h144, 33'h0, 33'h103, 1'b0));

      // Asynchronous reset with requests in flight
      do_reset();
      bus.cmd_ready_i = 1'b0;
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h600, 33'h0);
      step();
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h604, 33'h0);
      step();
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h608, 33'h0);
      set_rsp(0, 33'h5, 1'b0);
      set_rsp(1, 33'h6, 1'b0);
      step();
      clear_in();
      step();
      check("areset_pre_valid", bus.cmd_valid_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_valid", bus.cmd_valid_o, 0);
      check("areset_cmd", bus.cmd_o, 0);
      check("areset_flags", {pend_ovf, orphan, cpl_drop, drop_cnt}, 0);
      step();
      rst_n = 1'b1;
      bus.cmd_ready_i = 1'b1;
      got.delete();
      set_req(0, 1'b0, 1'b0, 4'hF, 32'h700, 33'h0);
      step();
      clear_in();
      set_rsp(0, 33'h42, 1'b0);
      step();
      clear_in();
      repeat (4) step();
      check("areset_count", got.size(), 1);
      check("areset_seq0", got_at(0), mk_rec(8'h00, 1'b0, 1'b0, 4'hF, 30'h1C0, 33'h0, 33'h42, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
